// File: rtl/apb_pkg.sv
// apb_pkg: bus widths and requester state encoding shared by the APB master, slave and benches
package apb_pkg;
  localparam int DATAWIDTH = 32;
  localparam int ADDRWIDTH = 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
endpackage

// File: rtl/apb_master_timeout.sv
// apb_master_timeout: counts stalled ACCESS cycles and flags the last one allowed before abort
module apb_master_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic stall,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= active ? cnt + W'(stall) : '0;
  assign expired = active & stall & (cnt == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/apb_master.sv
// apb_master: turns one-at-a-time valid/ready commands into APB transfers with a response strobe.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb_master #(
  parameter int DATAWIDTH      = 32,
  parameter int ADDRWIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 PSEL,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0] PWDATA,
  input  logic [DATAWIDTH-1:0] PRDATA,
  input  logic                 PREADY
);
  import apb_pkg::*;
  apb_state_t state;
  logic done, timeout;
  assign done      = (state == ACCESS) & PREADY;
  assign cmd_ready = (state == IDLE) | done;
`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(PCLK),
    .rst_n(PRESETn),
    .active(state == ACCESS),
    .stall(!PREADY),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif
  // A command taken while completing goes straight to SETUP so PSEL never drops between transfers
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done | timeout;
      if (done | timeout) begin
        rsp_rdata <= (done & !PWRITE) ? PRDATA : '0;
        rsp_err   <= timeout;
      end
      if (cmd_valid & cmd_ready) begin
        state  <= SETUP;
        PSEL   <= 1'b1;
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        if (cmd_write) PWDATA <= cmd_wdata;
      end else if (state == SETUP) begin
        state <= ACCESS;
      end else if (done | timeout) begin
        state <= IDLE;
        PSEL  <= 1'b0;
      end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized scoreboard bench for apb_master driving a behavioural APB slave
module tb_apb_master;
  typedef struct packed {logic err; logic [31:0] d;} rsp_t;
  logic PCLK = 0, PRESETn = 0;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, PADDR;
  logic [31:0] cmd_wdata, rsp_rdata, PWDATA, PRDATA;
  logic rsp_valid, rsp_err, PSEL, PWRITE;
  logic PREADY = 1;
  rsp_t exp_q[$];
  rsp_t e;
  logic [31:0] refmem [256];
  logic [31:0] smem [256];
  int checks = 0, failures = 0, cyc = 0, rsp_cnt = 0, last_rsp_cyc = 0, acc_cyc = 0, issued = 0;
  int psel_cyc = 0, low_cnt = 0, sel_cyc = 0, wait_n = 0, rmode = 0;
  int ac, a1, rc;
  logic [7:0] pa = 0;
  logic pw = 0, pp = 0, done_edge = 0;
  logic [31:0] pd = 0;

  apb_master dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave model: sel_cyc==0 is the SETUP cycle, >0 counts ACCESS cycles of the current transfer
  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    done_edge <= PSEL && sel_cyc > 0 && PREADY;
    if (PSEL && sel_cyc > 0 && PREADY && PWRITE) smem[PADDR] <= PWDATA;
    sel_cyc <= !PSEL ? 0 : (sel_cyc > 0 && PREADY) ? 0 : sel_cyc + 1;
  end
  assign PRDATA = smem[PADDR];

  always @(negedge PCLK) begin
    if (PSEL) psel_cyc++; else low_cnt++;
    if (PSEL && pp && !done_edge) chk("bus_stable", {PADDR, PWRITE, PWDATA}, {pa, pw, pd});
    if (rsp_valid) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp", {rsp_err, rsp_rdata}, e);
      end
    end
    {pa, pw, pd} = {PADDR, PWRITE, PWDATA};
    pp = PSEL;
    PREADY = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) :
             rmode == 2 ? (sel_cyc > wait_n) : 1'b0;
  end

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d, input bit hold);
    bit ok = 0;
    @(negedge PCLK);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int t = 0; t < 300 && !ok; t++) begin
      #4;
      if (cmd_ready) begin
        ok = 1;
        acc_cyc = cyc;
        issued++;
        exp_q.push_back(rsp_t'{rmode == 3, (w || rmode == 3) ? 32'h0 : refmem[a]});
        if (w && rmode != 3) refmem[a] = d;
      end
      @(posedge PCLK);
      if (!ok) @(negedge PCLK);
    end
    #1;
    if (!hold) cmd_valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    cmd_valid = 0;
    for (int t = 0; t < 2000 && exp_q.size() > 0; t++) @(negedge PCLK);
    @(negedge PCLK);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    #12;
    chk("rst_bus", {PSEL, PWRITE, PADDR, PWDATA}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    @(negedge PCLK); PRESETn = 1;
    @(negedge PCLK);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel_after", PSEL, 0);
    // single write, PREADY tied high
    rmode = 0; psel_cyc = 0;
    issue(1, 8'h05, 32'hDEADBEEF, 0); ac = acc_cyc;
    @(negedge PCLK);
    chk("wr_bus", {PSEL, PWRITE, PADDR, PWDATA}, {1'b1, 1'b1, 8'h05, 32'hDEADBEEF});
    drain();
    chk("wr_latency", last_rsp_cyc - ac, 3);
    chk("wr_psel_cycles", psel_cyc, 2);
    // full address sweep with random wait states
    rmode = 1; rc = rsp_cnt;
    for (int i = 0; i < 256; i++) issue(1, 8'(i), 32'(i), bit'($urandom_range(0, 1)));
    for (int i = 0; i < 256; i++) issue(0, 8'(i), 32'h0, bit'($urandom_range(0, 1)));
    drain();
    chk("sweep_rsp_count", rsp_cnt - rc, 512);
    // read with four stalled ACCESS cycles
    rmode = 2; wait_n = 4; psel_cyc = 0;
    issue(0, 8'h10, 32'h0, 0); ac = acc_cyc;
    drain();
    chk("wait_latency", last_rsp_cyc - ac, 7);
    chk("wait_psel_cycles", psel_cyc, 6);
    // back-to-back writes with cmd_valid held
    rmode = 0;
    issue(1, 8'h01, $urandom, 1); a1 = acc_cyc; low_cnt = 0;
    issue(1, 8'h02, $urandom, 0);
    chk("b2b_spacing", acc_cyc - a1, 2);
    chk("b2b_psel_gap", low_cnt, 0);
    chk("b2b_setup_bus", {PSEL, PADDR}, {1'b1, 8'h02});
    drain();
    // reset during ACCESS
    rmode = 3; rc = rsp_cnt;
    issue(0, 8'h33, 32'h0, 0);
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 0;
    #1;
    chk("midrst_bus", {PSEL, PWRITE, PADDR, PWDATA}, 0);
    chk("midrst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    exp_q.delete();
    issued--;
    @(negedge PCLK); PRESETn = 1; rmode = 0;
    repeat (4) @(negedge PCLK);
    chk("midrst_no_rsp", rsp_cnt - rc, 0);
    issue(1, 8'h44, $urandom, 0);
    issue(0, 8'h44, 32'h0, 0);
    drain();
    chk("midrst_recover", rsp_cnt - rc, 2);
    // random mix
    rmode = 1;
    for (int i = 0; i < 200; i++)
      issue(1'($urandom_range(0, 1)), 8'($urandom), $urandom, bit'($urandom_range(0, 1)));
    drain();
`ifdef APB_MASTER_TIMEOUT_EN
    rmode = 3; psel_cyc = 0;
    issue(0, 8'h20, 32'h0, 0); ac = acc_cyc;
    drain();
    chk("to_latency", last_rsp_cyc - ac, 18);
    chk("to_psel_cycles", psel_cyc, 17);
    rmode = 0;
    issue(0, 8'h20, 32'h0, 0);
    drain();
`endif
    chk("total_rsp", rsp_cnt, issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
